ifu32: RTL and testbench
========================

// Module: ifu32
// PURPOSE
//  Instruction fetch unit feeding the GPC32 single-cycle core. Takes the core's PC and issues one
//  request at a time on the instruction-memory req/gnt/rvalid bus. Holds the returned word stable on
//  inst until the core retires it. Also handles redirect flushes, misalignment, bus errors and
//  response timeouts.
// PARAMETERS
//  WIDTH     32            address/PC width
//  INST_MAX  32            instruction word width
//  TIMEOUT   255           cycles waiting for rvalid before timeout fault; 0 disables
//  TO_WIDTH  8             watchdog counter width, >= clog2(TIMEOUT+1)
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         synchronous, active-high reset
//  fetch_en    in   1         core requests a fetch at fetch_pc
//  fetch_pc    in   WIDTH     PC to fetch; sampled only in IDLE when fetch_en=1
//  flush       in   1         one-cycle redirect: abandon current fetch
//  inst        out  INST_MAX  fetched instruction; stable while inst_valid=1
//  inst_valid  out  1         inst/inst_fault valid (HOLD state)
//  inst_ready  in   1         core accepts inst this cycle
//  inst_fault  out  2         0 none, 1 misaligned, 2 bus error, 3 timeout
//  imem_req    out  1         request valid
//  imem_addr   out  WIDTH     request address = latched PC; stable while imem_req=1
//  imem_gnt    in   1         request accepted this cycle
//  imem_rvalid in   1         response valid; at most one outstanding request
//  imem_rdata  in   INST_MAX  response data
//  imem_err    in   1         bus error, qualified by imem_rvalid
// BEHAVIOUR
//  Reset: state=IDLE; inst=0, inst_valid=0, inst_fault=0, imem_req=0, imem_addr=0, watchdog=0.
//  All outputs are registered. Nothing is driven combinationally from inputs.
//  FSM:
//   IDLE : on fetch_en, latch fetch_pc.
//          If fetch_pc[1:0]!=0: go to HOLD with fault=1 and inst=NOP (32'h0000_0013).
//          Otherwise go to REQ.
//   REQ  : imem_req=1. On imem_gnt, go to WAIT and clear the watchdog.
//   WAIT : on imem_rvalid, capture inst=imem_rdata (NOP if imem_err, fault=2) and go to HOLD.
//          If watchdog reaches TIMEOUT without rvalid: inst=NOP, fault=3, go to HOLD.
//   HOLD : inst_valid=1. On inst_ready, go to IDLE and clear inst_valid and fault next cycle.
//   DRAIN: an orphaned response is in flight. On rvalid, drop the data and go to IDLE.
//          On watchdog TIMEOUT, go to IDLE silently.
//  Latency: zero-wait memory (gnt in REQ, rvalid the next cycle) gives fetch_en@T0 -> inst_valid@T3.
//  Throughput is one instruction per 4 cycles.
//  imem_req is never withdrawn before gnt, except on flush.
//  flush has priority over every other input:
//   IDLE: no-op. HOLD: go to IDLE, inst discarded.
//   REQ without gnt the same cycle: drop imem_req, go to IDLE.
//   REQ with gnt the same cycle: go to DRAIN.
//   WAIT with rvalid the same cycle: drop the data, go to IDLE.
//   WAIT without rvalid: go to DRAIN.
//   DRAIN: no-op.
//  Watchdog counts only in WAIT/DRAIN, saturates at TIMEOUT, and is held at 0 when TIMEOUT=0.
//  rvalid in IDLE/REQ/HOLD is a protocol error. It is ignored, and the bench asserts it never occurs.
//  rst mid-transaction returns to IDLE. The testbench memory is reset alongside, so no drain is needed.
// STRUCTURE
//  Shared header gpc_defs.vh: FSM state encodings, fault codes (FLT_NONE/MIS/BUS/TMO), NOP_INST.
//  Sub-module ifu_wdog: TO_WIDTH saturating counter with clr/en inputs and an expired output.
//  All other logic is flat in ifu32.
// TESTING
//  1. Zero-wait memory, fetch_pc=0x8000_0000, mem returns 0x0010_0093
//     -> imem_addr=0x8000_0000, inst_valid@T3, inst=0x0010_0093, fault=0.
//  2. Hold inst_ready=0 for 5 cycles -> inst and inst_valid stay stable; ready@T8 -> inst_valid=0@T9.
//  3. fetch_pc=0x8000_0002 -> no imem_req; HOLD with fault=1, inst=0x0000_0013.
//  4. gnt immediate, rvalid delayed 3 cycles, flush in WAIT -> DRAIN; rvalid data dropped;
//     next fetch 0x8000_0100 returns its own data, never the stale word.
//  5. Response with imem_err=1 -> fault=2, inst=NOP. No rvalid, TIMEOUT=4 -> fault=3 after 4 WAIT cycles.
//  6. flush same cycle as gnt -> DRAIN. rst asserted in WAIT -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/ifu32_pkg.sv
// ifu32_pkg: shared definitions for the instruction fetch unit.
//   FSM state encodings, fault codes reported on inst_fault_o, and the
//   instruction substituted for a word that could not be fetched.
package ifu32_pkg;

    typedef logic [1:0] fault_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam fault_t FLT_NONE = 2'd0;
    localparam fault_t FLT_MIS  = 2'd1;
    localparam fault_t FLT_BUS  = 2'd2;
    localparam fault_t FLT_TMO  = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifu32_wdog.sv
// ifu32_wdog: saturating response watchdog.
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clr_i      restart the count from zero
//   en_i       count this cycle
//   expired_o  high in the counting cycle in which the count reaches TIMEOUT
//              (and every counting cycle after); never high when TIMEOUT=0
module ifu32_wdog #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_WIDTH-1:0] CNT_MAX  = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (TIMEOUT == 0) begin
            cnt_d = '0;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Flag the cycle whose increment lands on TIMEOUT so the FSM leaves
    // after exactly TIMEOUT counting cycles.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/ifu32.sv
// ifu32: instruction fetch unit for the GPC32 core.
//   Issues one request at a time on the imem req/gnt/rvalid bus for the PC
//   presented by the core and holds the result until the core retires it.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     fetch_en_i, fetch_pc_i       fetch request and PC (sampled in IDLE)
//     flush_i                      redirect: abandon the current fetch
//     inst_o, inst_valid_o,
//     inst_fault_o, inst_ready_i   instruction handoff to the core
//     imem_req_o, imem_addr_o,
//     imem_gnt_i                   request channel
//     imem_rvalid_i, imem_rdata_i,
//     imem_err_i                   response channel
//   All outputs come straight from registers.
//
//   state | meaning
//   IDLE  | waiting for fetch_en
//   REQ   | imem_req high, waiting for gnt
//   WAIT  | granted, waiting for rvalid (watchdog running)
//   HOLD  | inst/fault presented until inst_ready
//   DRAIN | flushed with a response still in flight; swallow it
module ifu32 #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned INST_MAX = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fetch_en_i,
    input  logic [WIDTH-1:0]    fetch_pc_i,
    input  logic                flush_i,
    output logic [INST_MAX-1:0] inst_o,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [1:0]          inst_fault_o,
    output logic                imem_req_o,
    output logic [WIDTH-1:0]    imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INST_MAX-1:0] imem_rdata_i,
    input  logic                imem_err_i
);

    import ifu32_pkg::*;

    localparam logic [INST_MAX-1:0] NOP = INST_MAX'(NOP_INST);

    logic [2:0]          state_q, state_d;
    logic [INST_MAX-1:0] inst_q, inst_d;
    logic                valid_q, valid_d;
    fault_t              fault_q, fault_d;
    logic                req_q, req_d;
    logic [WIDTH-1:0]    addr_q, addr_d;

    logic wd_clr, wd_en, wd_expired;

    assign wd_en = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    ifu32_wdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        fault_d = fault_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wd_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fetch_en_i && !flush_i) begin
                    addr_d = fetch_pc_i;
                    if (fetch_pc_i[1:0] != 2'b00) begin
                        state_d = ST_HOLD;
                        inst_d  = NOP;
                        fault_d = FLT_MIS;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    // Once granted the response is owed, so a flush here
                    // still has to wait it out in DRAIN.
                    wd_clr  = 1'b1;
                    req_d   = 1'b0;
                    state_d = flush_i ? ST_DRAIN : ST_WAIT;
                end else if (flush_i) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        inst_d  = imem_err_i ? NOP : imem_rdata_i;
                        fault_d = imem_err_i ? FLT_BUS : FLT_NONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else if (wd_expired) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    inst_d  = NOP;
                    fault_d = FLT_TMO;
                end
            end
            ST_HOLD: begin
                if (flush_i || inst_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    fault_d = FLT_NONE;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i || wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= FLT_NONE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign inst_fault_o = fault_q;
    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;

endmodule

// File: tb/tb_ifu32.sv
// tb_ifu32: directed bench for ifu32 with a scoreboard of expected
// instruction/fault pairs, pushed when a fetch is launched and popped when
// the DUT presents inst_valid.
module tb_ifu32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [1:0]  fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  inst_fault;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ifu32 #(
        .WIDTH    (32),
        .INST_MAX (32),
        .TIMEOUT  (4),
        .TO_WIDTH (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_en_i    (fetch_en),
        .fetch_pc_i    (fetch_pc),
        .flush_i       (flush),
        .inst_o        (inst),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (inst_ready),
        .inst_fault_o  (inst_fault),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .imem_err_i    (imem_err)
    );

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [1:0] f);
        exp_t e;
        e.inst  = i;
        e.fault = f;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed output with empty scoreboard, expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
            chk({tag, "_inst"}, inst, e.inst);
            chk({tag, "_fault"}, 32'(inst_fault), 32'(e.fault));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!inst_valid && k < budget) begin
            step();
            k++;
        end
        if (!inst_valid) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_wait: observed no inst_valid after %0d cycles, expected inst_valid", tag, budget);
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_en = 1'b1;
        fetch_pc = pc;
        step();
        fetch_en = 1'b0;
    endtask

    task automatic retire(input string tag);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk({tag, "_retired"}, 32'(inst_valid), 32'd0);
    endtask

    // Zero-wait memory: gnt in the REQ cycle, rvalid the cycle after.
    task automatic fetch_zw(input string tag, input logic [31:0] pc,
                            input logic [31:0] data, input logic err);
        fetch(pc);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, pc);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        imem_err    = err;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_err    = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        fetch_en    = 1'b0;
        fetch_pc    = '0;
        flush       = 1'b0;
        inst_ready  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_err    = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_inst", inst, 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(inst_fault), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;
        step();

        // 1. Zero-wait fetch: inst_valid lands exactly at T3
        push(32'h0010_0093, 2'd0);
        fetch_zw("t1", 32'h8000_0000, 32'h0010_0093, 1'b0);
        pop_check("t1");

        // 2. Core stalls for 5 cycles; output stays put
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", 32'(inst_valid), 32'd1);
            chk("t2_hold_inst", inst, 32'h0010_0093);
        end
        retire("t2");
        chk("t2_fault_clr", 32'(inst_fault), 32'd0);

        // 3. Misaligned PC: straight to HOLD, bus untouched
        push(NOP, 2'd1);
        fetch(32'h8000_0002);
        chk("t3_no_req", 32'(imem_req), 32'd0);
        pop_check("t3");
        retire("t3");

        // 4. Flush in WAIT, late response must be swallowed
        fetch(32'h8000_0040);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_drain_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("t4_drop_valid", 32'(inst_valid), 32'd0);
        step();
        chk("t4_idle_valid", 32'(inst_valid), 32'd0);
        push(32'h0020_0113, 2'd0);
        fetch_zw("t4b", 32'h8000_0100, 32'h0020_0113, 1'b0);
        pop_check("t4b");
        retire("t4b");

        // 5a. Bus error
        push(NOP, 2'd2);
        fetch_zw("t5a", 32'h8000_0200, 32'hFFFF_FFFF, 1'b1);
        pop_check("t5a");
        retire("t5a");

        // 5b. No response: timeout after 4 WAIT cycles
        push(NOP, 2'd3);
        fetch(32'h8000_0300);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        repeat (3) step();
        chk("t5b_not_yet", 32'(inst_valid), 32'd0);
        step();
        wait_valid("t5b", 1);
        pop_check("t5b");
        retire("t5b");

        // 6a. Flush in the same cycle as gnt -> DRAIN, response dropped
        fetch(32'h8000_0400);
        imem_gnt = 1'b1;
        flush    = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush    = 1'b0;
        chk("t6a_req", 32'(imem_req), 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("t6a_drop_valid", 32'(inst_valid), 32'd0);
        push(32'h0030_0193, 2'd0);
        fetch_zw("t6a2", 32'h8000_0500, 32'h0030_0193, 1'b0);
        pop_check("t6a2");
        retire("t6a2");

        // 6b. Reset while waiting for a response
        fetch(32'h8000_0600);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6b_inst", inst, 32'd0);
        chk("t6b_valid", 32'(inst_valid), 32'd0);
        chk("t6b_fault", 32'(inst_fault), 32'd0);
        chk("t6b_req", 32'(imem_req), 32'd0);
        chk("t6b_addr", imem_addr, 32'd0);
        push(32'h0040_0213, 2'd0);
        fetch_zw("t6c", 32'h8000_0700, 32'h0040_0213, 1'b0);
        pop_check("t6c");
        retire("t6c");

        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
